// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache with a single outstanding refill.
// Hits return combinationally; misses block in MISS until the memory controller answers.
module icache #(
   parameter int INDEX_W = 7
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_jmp_wrong_i,
   input  logic        if_req,
   input  logic [31:0] if_pc,
   output logic [31:0] if_inst_o,
   output logic        if_inst_valid,
   output logic        if_stall,
   output logic        inst_require,
   output logic [31:0] inst_addr,
   input  logic [31:0] inst_data,
   input  logic        inst_enable
);

   localparam int LINES = 1 << INDEX_W;
   localparam int TAG_W = 30 - INDEX_W;

   typedef enum logic [1:0] {IDLE, MISS, RETURN} state_t;

   state_t              state, state_nx;
   logic [LINES-1:0]    line_valid;
   logic [TAG_W-1:0]    line_tag  [LINES];
   logic [31:0]         line_data [LINES];
   logic [31:0]         miss_addr;
   logic [31:0]         ret_word;
   logic [INDEX_W-1:0]  pc_idx, miss_idx;
   logic [TAG_W-1:0]    pc_tag, miss_tag;
   logic                hit, miss, refill;
   logic                unused_pc_bits;

   assign pc_idx         = if_pc[INDEX_W+1:2];
   assign pc_tag         = if_pc[31:INDEX_W+2];
   assign miss_idx       = miss_addr[INDEX_W+1:2];
   assign miss_tag       = miss_addr[31:INDEX_W+2];
   assign unused_pc_bits = ^if_pc[1:0];

   // A flush in IDLE masks the lookup entirely: no hit and no miss latched.
   assign hit    = (state == IDLE) && if_req && !ex_jmp_wrong_i &&
                   line_valid[pc_idx] && (line_tag[pc_idx] == pc_tag);
   assign miss   = (state == IDLE) && if_req && !ex_jmp_wrong_i && !hit;
   assign refill = (state == MISS) && inst_enable;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (miss) state_nx = MISS;
         MISS: begin
            if (ex_jmp_wrong_i)   state_nx = IDLE;
            else if (inst_enable) state_nx = RETURN;
         end
         RETURN:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      if_inst_valid = 1'b0;
      if_inst_o     = 32'h0;
      if_stall      = 1'b0;
      inst_require  = 1'b0;
      case (state)
         IDLE: begin
            if_inst_valid = hit;
            if (hit) if_inst_o = line_data[pc_idx];
         end
         MISS: begin
            if_stall     = 1'b1;
            inst_require = 1'b1;
         end
         RETURN: begin
            if_inst_valid = !ex_jmp_wrong_i;
            if_inst_o     = ret_word;
         end
         default: ;
      endcase
   end

   assign inst_addr = miss_addr;

   // Control state and valid bits are reset; line payload is not.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         miss_addr  <= 32'h0;
         ret_word   <= 32'h0;
         line_valid <= '0;
      end else begin
         if (miss)   miss_addr <= {if_pc[31:2], 2'b00};
         if (refill) begin
            ret_word             <= inst_data;
            line_valid[miss_idx] <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (refill) begin
         line_tag[miss_idx]  <= miss_tag;
         line_data[miss_idx] <= inst_data;
      end
   end

endmodule
